axi_burst_slave: RTL and testbench

Synthesizable AXI4 burst responder: the DRAM-side counterpart of the ISP's AXI master port. It serves INCR read and write bursts of 128-bit beats from an internal word array. It has independent read and write engines and one outstanding transaction per direction. It stands in for the DRAM model in block-level and FPGA bring-up benches.

---
 rtl/axi_burst_slave_if.sv | 58 +++++
 rtl/axi_burst_slave.sv | 246 ++++++++++++++++++++++++
 tb/tb_axi_burst_slave.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_slave_if.sv
// AXI4 bus between the ISP master port and the burst responder; the slave
// modport is the responder's view.
interface axi_burst_slave_if;
  logic [3:0]   awid_s_inf;
  logic [31:0]  awaddr_s_inf;
  logic [2:0]   awsize_s_inf;
  logic [1:0]   awburst_s_inf;
  logic [7:0]   awlen_s_inf;
  logic         awvalid_s_inf;
  logic         awready_s_inf;
  logic [127:0] wdata_s_inf;
  logic         wlast_s_inf;
  logic         wvalid_s_inf;
  logic         wready_s_inf;
  logic [3:0]   bid_s_inf;
  logic [1:0]   bresp_s_inf;
  logic         bvalid_s_inf;
  logic         bready_s_inf;
  logic [3:0]   arid_s_inf;
  logic [31:0]  araddr_s_inf;
  logic [7:0]   arlen_s_inf;
  logic [2:0]   arsize_s_inf;
  logic [1:0]   arburst_s_inf;
  logic         arvalid_s_inf;
  logic         arready_s_inf;
  logic [3:0]   rid_s_inf;
  logic [127:0] rdata_s_inf;
  logic [1:0]   rresp_s_inf;
  logic         rlast_s_inf;
  logic         rvalid_s_inf;
  logic         rready_s_inf;

  modport slave (
    input  awid_s_inf, awaddr_s_inf, awsize_s_inf, awburst_s_inf, awlen_s_inf, awvalid_s_inf,
    output awready_s_inf,
    input  wdata_s_inf, wlast_s_inf, wvalid_s_inf,
    output wready_s_inf,
    output bid_s_inf, bresp_s_inf, bvalid_s_inf,
    input  bready_s_inf,
    input  arid_s_inf, araddr_s_inf, arlen_s_inf, arsize_s_inf, arburst_s_inf, arvalid_s_inf,
    output arready_s_inf,
    output rid_s_inf, rdata_s_inf, rresp_s_inf, rlast_s_inf, rvalid_s_inf,
    input  rready_s_inf
  );

  modport master (
    output awid_s_inf, awaddr_s_inf, awsize_s_inf, awburst_s_inf, awlen_s_inf, awvalid_s_inf,
    input  awready_s_inf,
    output wdata_s_inf, wlast_s_inf, wvalid_s_inf,
    input  wready_s_inf,
    input  bid_s_inf, bresp_s_inf, bvalid_s_inf,
    output bready_s_inf,
    output arid_s_inf, araddr_s_inf, arlen_s_inf, arsize_s_inf, arburst_s_inf, arvalid_s_inf,
    input  arready_s_inf,
    input  rid_s_inf, rdata_s_inf, rresp_s_inf, rlast_s_inf, rvalid_s_inf,
    output rready_s_inf
  );
endinterface

// File: rtl/axi_burst_slave.sv
// AXI4 INCR burst responder over a 128-bit word array: independent read and
// write engines, one outstanding burst each, all outputs registered.
module axi_burst_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          DEPTH     = 1024,
  parameter int          RD_LAT    = 2
) (
  input logic clk,
  input logic rst_n,
  axi_burst_slave_if.slave s_inf
);
  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [28:0] DEPTH_W  = 29'(DEPTH);
  localparam logic [3:0]  LAT_LAST = 4'(RD_LAT - 1);
  localparam logic [1:0]  OKAY     = 2'b00;
  localparam logic [1:0]  SLVERR   = 2'b10;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic        legal;
  } burst_t;

  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [127:0] mem [DEPTH];

  function automatic logic legal_f(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [31:0] addr);
    return (size == 3'b100) && (burst == 2'b01) && (addr[3:0] == 4'h0);
  endfunction

  // 29-bit word index so a 256-beat burst near the top of the map cannot wrap back in range.
  function automatic logic [28:0] word_f(input logic [31:0] addr, input logic [8:0] beat);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return {1'b0, off[31:4]} + {20'd0, beat};
  endfunction

  function automatic logic in_range_f(input logic [31:0] addr, input logic [28:0] word);
    return (addr >= BASE_ADDR) && (word < DEPTH_W);
  endfunction

  // ---------------- read engine ----------------
  r_state_t    r_state, r_next;
  burst_t      r_req, r_req_d;
  logic [8:0]  r_beat, r_beat_d;
  logic [3:0]  lat_cnt, lat_d;
  logic        r_load, r_ok;
  logic [28:0] r_word;
  logic        arready_d, rvalid_d, rlast_d;
  logic [3:0]  rid_d;
  logic [1:0]  rresp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next    = r_state;
    r_req_d   = r_req;
    r_beat_d  = r_beat;
    lat_d     = lat_cnt;
    r_load    = 1'b0;
    arready_d = s_inf.arready_s_inf;
    rvalid_d  = s_inf.rvalid_s_inf;
    rid_d     = s_inf.rid_s_inf;
    rresp_d   = s_inf.rresp_s_inf;
    rlast_d   = s_inf.rlast_s_inf;
    case (r_state)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s_inf.arvalid_s_inf && s_inf.arready_s_inf) begin
          r_req_d   = '{id: s_inf.arid_s_inf, addr: s_inf.araddr_s_inf, len: s_inf.arlen_s_inf,
                        legal: legal_f(s_inf.arsize_s_inf, s_inf.arburst_s_inf, s_inf.araddr_s_inf)};
          rid_d     = s_inf.arid_s_inf;
          arready_d = 1'b0;
          r_beat_d  = 9'd0;
          lat_d     = 4'd0;
          if (RD_LAT == 0) begin
            r_load = 1'b1;
            r_next = R_DATA;
          end else begin
            r_next = R_LAT;
          end
        end
      end
      R_LAT: begin
        lat_d = lat_cnt + 4'd1;
        if (lat_cnt == LAT_LAST) begin
          r_load = 1'b1;
          r_next = R_DATA;
        end
      end
      R_DATA: begin
        if (s_inf.rready_s_inf) begin
          if (s_inf.rlast_s_inf) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            rresp_d   = OKAY;
            arready_d = 1'b1;
            r_next    = R_IDLE;
          end else begin
            r_beat_d = r_beat + 9'd1;
            r_load   = 1'b1;
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
    // Beat loads address the array with the next-cycle request/beat so the
    // first beat can come straight off the AR handshake when RD_LAT is 0.
    r_word = word_f(r_req_d.addr, r_beat_d);
    r_ok   = r_req_d.legal && in_range_f(r_req_d.addr, r_word);
    if (r_load) begin
      rvalid_d = 1'b1;
      rlast_d  = (r_beat_d == {1'b0, r_req_d.len});
      rresp_d  = r_ok ? OKAY : SLVERR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req               <= '0;
      r_beat              <= '0;
      lat_cnt             <= '0;
      s_inf.arready_s_inf <= 1'b0;
      s_inf.rvalid_s_inf  <= 1'b0;
      s_inf.rid_s_inf     <= '0;
      s_inf.rresp_s_inf   <= '0;
      s_inf.rlast_s_inf   <= 1'b0;
      s_inf.rdata_s_inf   <= '0;
    end else begin
      r_req               <= r_req_d;
      r_beat              <= r_beat_d;
      lat_cnt             <= lat_d;
      s_inf.arready_s_inf <= arready_d;
      s_inf.rvalid_s_inf  <= rvalid_d;
      s_inf.rid_s_inf     <= rid_d;
      s_inf.rresp_s_inf   <= rresp_d;
      s_inf.rlast_s_inf   <= rlast_d;
      if (r_load) s_inf.rdata_s_inf <= r_ok ? mem[r_word[AW-1:0]] : '0;
    end
  end

  // ---------------- write engine ----------------
  w_state_t    w_state, w_next;
  burst_t      w_req, w_req_d;
  logic [8:0]  w_beat, w_beat_d;
  logic        w_err, w_err_d;
  logic        w_in, w_last_beat, mem_we;
  logic [28:0] w_word;
  logic        awready_d, wready_d, bvalid_d;
  logic [3:0]  bid_d;
  logic [1:0]  bresp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next      = w_state;
    w_req_d     = w_req;
    w_beat_d    = w_beat;
    w_err_d     = w_err;
    mem_we      = 1'b0;
    awready_d   = s_inf.awready_s_inf;
    wready_d    = s_inf.wready_s_inf;
    bvalid_d    = s_inf.bvalid_s_inf;
    bid_d       = s_inf.bid_s_inf;
    bresp_d     = s_inf.bresp_s_inf;
    w_word      = word_f(w_req.addr, w_beat);
    w_in        = in_range_f(w_req.addr, w_word);
    w_last_beat = (w_beat == {1'b0, w_req.len});
    case (w_state)
      W_IDLE: begin
        awready_d = 1'b1;
        if (s_inf.awvalid_s_inf && s_inf.awready_s_inf) begin
          w_req_d   = '{id: s_inf.awid_s_inf, addr: s_inf.awaddr_s_inf, len: s_inf.awlen_s_inf,
                        legal: legal_f(s_inf.awsize_s_inf, s_inf.awburst_s_inf, s_inf.awaddr_s_inf)};
          w_err_d   = !w_req_d.legal;
          bid_d     = s_inf.awid_s_inf;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_beat_d  = 9'd0;
          w_next    = W_DATA;
        end
      end
      W_DATA: begin
        if (s_inf.wvalid_s_inf && s_inf.wready_s_inf) begin
          mem_we  = w_req.legal && w_in;
          // The beat count, not wlast, closes the burst; a misplaced wlast only flags the response.
          w_err_d = w_err || !w_in || (s_inf.wlast_s_inf != w_last_beat);
          if (w_last_beat) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = w_err_d ? SLVERR : OKAY;
            w_next   = W_RESP;
          end else begin
            w_beat_d = w_beat + 9'd1;
          end
        end
      end
      W_RESP: begin
        if (s_inf.bready_s_inf) begin
          bvalid_d  = 1'b0;
          bresp_d   = OKAY;
          awready_d = 1'b1;
          w_next    = W_IDLE;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_req               <= '0;
      w_beat              <= '0;
      w_err               <= 1'b0;
      s_inf.awready_s_inf <= 1'b0;
      s_inf.wready_s_inf  <= 1'b0;
      s_inf.bvalid_s_inf  <= 1'b0;
      s_inf.bid_s_inf     <= '0;
      s_inf.bresp_s_inf   <= '0;
    end else begin
      w_req               <= w_req_d;
      w_beat              <= w_beat_d;
      w_err               <= w_err_d;
      s_inf.awready_s_inf <= awready_d;
      s_inf.wready_s_inf  <= wready_d;
      s_inf.bvalid_s_inf  <= bvalid_d;
      s_inf.bid_s_inf     <= bid_d;
      s_inf.bresp_s_inf   <= bresp_d;
    end
  end

  // Array contents are deliberately not reset so they survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[w_word[AW-1:0]] <= s_inf.wdata_s_inf;
  end
endmodule

// File: tb/tb_axi_burst_slave.sv
// Directed + randomized bursts against a word-array model of the responder;
// expected beats come from address arithmetic on the model array.
module tb_axi_burst_slave;
  localparam logic [31:0] BASE   = 32'h0001_0000;
  localparam int          DEPTH  = 2048;
  localparam int          RD_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_burst_slave_if bus ();

  axi_burst_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .s_inf(bus)
  );

  logic [127:0] model [DEPTH];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_map(input logic [31:0] addr, input int k);
    if (addr < BASE) return 1'b0;
    return (longint'((addr - BASE) >> 4) + longint'(k)) < longint'(DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] addr, input int k);
    return int'((addr - BASE) >> 4) + k;
  endfunction

  function automatic bit is_legal(input logic [31:0] addr, input logic [2:0] size, input logic [1:0] burst);
    return (size == 3'b100) && (burst == 2'b01) && (addr[3:0] == 4'h0);
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int wlast_beat,
                          input int gap_pct, input bit seq_data, input string tag);
    bit legal, err;
    int k, cyc, wait_b;
    logic [127:0] d;
    logic [1:0] exp_resp;
    legal = is_legal(addr, size, burst);
    err = !legal || (wlast_beat != int'(len));
    @(negedge clk);
    chk({tag, ":wready_pre_aw"}, bus.wready_s_inf, 1'b0);
    bus.awid_s_inf = id; bus.awaddr_s_inf = addr; bus.awlen_s_inf = len;
    bus.awsize_s_inf = size; bus.awburst_s_inf = burst; bus.awvalid_s_inf = 1'b1;
    cyc = 0;
    while (!bus.awready_s_inf && cyc < 100) begin @(negedge clk); cyc++; end
    chk({tag, ":aw_wait"}, cyc < 100, 1'b1);
    @(negedge clk);
    bus.awvalid_s_inf = 1'b0;
    chk({tag, ":awready_low"}, bus.awready_s_inf, 1'b0);
    chk({tag, ":wready_up"}, bus.wready_s_inf, 1'b1);
    k = 0; cyc = 0;
    while (k <= int'(len) && cyc < 4000) begin
      d = seq_data ? 128'(k + 1) : {$urandom, $urandom, $urandom, $urandom};
      bus.wvalid_s_inf = ($urandom_range(99) >= gap_pct);
      bus.wdata_s_inf = d;
      bus.wlast_s_inf = (k == wlast_beat);
      if (bus.wvalid_s_inf && bus.wready_s_inf) begin
        if (!in_map(addr, k)) err = 1'b1;
        else if (legal) model[widx(addr, k)] = d;
        k++;
      end
      @(negedge clk); cyc++;
    end
    bus.wvalid_s_inf = 1'b0; bus.wlast_s_inf = 1'b0;
    exp_resp = err ? 2'b10 : 2'b00;
    chk({tag, ":w_beats"}, k, int'(len) + 1);
    if (gap_pct == 0) chk({tag, ":w_cycles"}, cyc, int'(len) + 1);
    chk({tag, ":wready_end"}, bus.wready_s_inf, 1'b0);
    chk({tag, ":bvalid"}, bus.bvalid_s_inf, 1'b1);
    chk({tag, ":bid"}, bus.bid_s_inf, id);
    chk({tag, ":bresp"}, bus.bresp_s_inf, exp_resp);
    wait_b = $urandom_range(0, 2);
    for (int i = 0; i < wait_b; i++) begin
      @(negedge clk);
      chk({tag, ":bvalid_hold"}, bus.bvalid_s_inf, 1'b1);
      chk({tag, ":bresp_hold"}, bus.bresp_s_inf, exp_resp);
    end
    bus.bready_s_inf = 1'b1;
    @(negedge clk);
    bus.bready_s_inf = 1'b0;
    chk({tag, ":bvalid_drop"}, bus.bvalid_s_inf, 1'b0);
    chk({tag, ":awready_back"}, bus.awready_s_inf, 1'b1);
  endtask

  // rdy_mode: 0 = rready held high, 1 = repeating 1,0,0,1, 2 = random.
  // rst_at >= 0 pulses rst_n while beat rst_at is on the bus and abandons the burst.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int rdy_mode,
                         input int rst_at, input string tag);
    bit legal, ok, rdy;
    int k, cyc, ph;
    logic [127:0] exp_d;
    legal = is_legal(addr, size, burst);
    @(negedge clk);
    bus.arid_s_inf = id; bus.araddr_s_inf = addr; bus.arlen_s_inf = len;
    bus.arsize_s_inf = size; bus.arburst_s_inf = burst; bus.arvalid_s_inf = 1'b1;
    bus.rready_s_inf = 1'b0;
    cyc = 0;
    while (!bus.arready_s_inf && cyc < 100) begin @(negedge clk); cyc++; end
    chk({tag, ":ar_wait"}, cyc < 100, 1'b1);
    @(negedge clk);
    bus.arvalid_s_inf = 1'b0;
    chk({tag, ":arready_low"}, bus.arready_s_inf, 1'b0);
    cyc = 0;
    while (!bus.rvalid_s_inf && cyc < 40) begin @(negedge clk); cyc++; end
    chk({tag, ":latency"}, cyc, RD_LAT);
    k = 0; cyc = 0; ph = 0;
    while (k <= int'(len) && cyc < 4000) begin
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (ph % 4 == 0) || (ph % 4 == 3);
        default: rdy = $urandom_range(1);
      endcase
      ph++;
      bus.rready_s_inf = rdy;
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, ":rst_rvalid"}, bus.rvalid_s_inf, 1'b0);
        chk({tag, ":rst_arready"}, bus.arready_s_inf, 1'b0);
        chk({tag, ":rst_rdata"}, bus.rdata_s_inf, '0);
        bus.rready_s_inf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({tag, ":rel_arready_low"}, bus.arready_s_inf, 1'b0);
        @(negedge clk);
        chk({tag, ":rel_arready"}, bus.arready_s_inf, 1'b1);
        chk({tag, ":rel_awready"}, bus.awready_s_inf, 1'b1);
        return;
      end
      ok = legal && in_map(addr, k);
      exp_d = ok ? model[widx(addr, k)] : '0;
      chk({tag, ":rvalid"}, bus.rvalid_s_inf, 1'b1);
      chk({tag, ":rid"}, bus.rid_s_inf, id);
      chk({tag, ":rdata"}, bus.rdata_s_inf, exp_d);
      chk({tag, ":rresp"}, bus.rresp_s_inf, ok ? 2'b00 : 2'b10);
      chk({tag, ":rlast"}, bus.rlast_s_inf, k == int'(len));
      if (rdy) k++;
      @(negedge clk); cyc++;
    end
    bus.rready_s_inf = 1'b0;
    chk({tag, ":r_beats"}, k, int'(len) + 1);
    if (rdy_mode == 0) chk({tag, ":r_cycles"}, cyc, int'(len) + 1);
    chk({tag, ":rvalid_end"}, bus.rvalid_s_inf, 1'b0);
    chk({tag, ":arready_back"}, bus.arready_s_inf, 1'b1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, w;
    bus.awid_s_inf = '0; bus.awaddr_s_inf = '0; bus.awsize_s_inf = '0; bus.awburst_s_inf = '0;
    bus.awlen_s_inf = '0; bus.awvalid_s_inf = 1'b0; bus.wdata_s_inf = '0; bus.wlast_s_inf = 1'b0;
    bus.wvalid_s_inf = 1'b0; bus.bready_s_inf = 1'b0; bus.arid_s_inf = '0; bus.araddr_s_inf = '0;
    bus.arlen_s_inf = '0; bus.arsize_s_inf = '0; bus.arburst_s_inf = '0; bus.arvalid_s_inf = 1'b0;
    bus.rready_s_inf = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset:arready", bus.arready_s_inf, 1'b0);
    chk("reset:awready", bus.awready_s_inf, 1'b0);
    chk("reset:rvalid", bus.rvalid_s_inf, 1'b0);
    chk("reset:wready", bus.wready_s_inf, 1'b0);
    chk("reset:bvalid", bus.bvalid_s_inf, 1'b0);
    chk("reset:rdata", bus.rdata_s_inf, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release:arready", bus.arready_s_inf, 1'b1);
    chk("release:awready", bus.awready_s_inf, 1'b1);

    // Fill the whole array with 256-beat bursts so every later read has a known value.
    for (int i = 0; i < DEPTH / 256; i++)
      do_write(4'(i), BASE + 32'(i * 4096), 8'd255, 3'b100, 2'b01, 255, 0, 1'b0, "fill");

    do_write(4'h3, BASE, 8'd3, 3'b100, 2'b01, 3, 0, 1'b1, "basic_wr");
    do_read(4'h9, BASE, 8'd3, 3'b100, 2'b01, 0, -1, "basic_rd");

    do_write(4'h5, BASE + 32'(3072 * 5), 8'd191, 3'b100, 2'b01, 191, 0, 1'b0, "b192_wr");
    do_read(4'h6, BASE + 32'(3072 * 5), 8'd191, 3'b100, 2'b01, 0, -1, "b192_rd");

    do_read(4'h2, BASE + 32'(16 * 40), 8'd15, 3'b100, 2'b01, 1, -1, "rready_pat");

    do_write(4'h6, BASE + 32'(16 * (DEPTH - 1)), 8'd1, 3'b100, 2'b01, 1, 0, 1'b0, "top_wr");
    do_read(4'h7, BASE + 32'(16 * (DEPTH - 1)), 8'd1, 3'b100, 2'b01, 0, -1, "top_rd");

    do_write(4'h7, BASE + 32'(16 * 200), 8'd3, 3'b100, 2'b01, 1, 0, 1'b0, "early_wlast_wr");
    do_read(4'h8, BASE + 32'(16 * 200), 8'd3, 3'b100, 2'b01, 0, -1, "early_wlast_rd");

    do_write(4'h8, BASE + 32'(16 * 300), 8'd2, 3'b011, 2'b01, 2, 0, 1'b0, "bad_size_wr");
    do_read(4'h9, BASE + 32'(16 * 300), 8'd2, 3'b100, 2'b01, 0, -1, "bad_size_chk");
    do_read(4'ha, BASE + 32'(16 * 300), 8'd2, 3'b100, 2'b10, 0, -1, "wrap_rd");
    do_read(4'hb, BASE + 32'(16 * 5 + 4), 8'd1, 3'b100, 2'b01, 0, -1, "misalign_rd");
    do_read(4'hc, BASE - 32'd32, 8'd3, 3'b100, 2'b01, 0, -1, "below_base_rd");
    do_read(4'hd, BASE + 32'(16 * 7), 8'd0, 3'b100, 2'b01, 0, -1, "len0_rd");
    do_read(4'he, BASE + 32'(16 * 512), 8'd255, 3'b100, 2'b01, 2, -1, "len255_rd");

    fork
      do_write(4'h1, BASE + 32'(16 * 600), 8'd15, 3'b100, 2'b01, 15, 30, 1'b0, "conc_wr");
      do_read(4'h4, BASE + 32'(16 * 700), 8'd15, 3'b100, 2'b01, 2, -1, "conc_rd");
    join

    for (int i = 0; i < 12; i++) begin
      len = $urandom_range(0, 31);
      w = $urandom_range(0, DEPTH - 1 - len);
      do_write(4'($urandom), BASE + 32'(16 * w), 8'(len), 3'b100, 2'b01, len, 25, 1'b0, "rand_wr");
      do_read(4'($urandom), BASE + 32'(16 * w), 8'(len), 3'b100, 2'b01, 2, -1, "rand_rd");
    end

    do_read(4'h1, BASE + 32'(16 * 100), 8'd80, 3'b100, 2'b01, 0, 50, "rst_mid_rd");
    do_read(4'h2, BASE + 32'(16 * 100), 8'd7, 3'b100, 2'b01, 0, -1, "post_rst_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
